mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported unified memory between the core's instruction-fetch port and its data port. Each requester side uses the valid/ready handshake already used on the memory bus. The arbiter serialises accesses, drives the memory-side bus and routes the response back to the granted requester. A watchdog completes any access whose memory never responds.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_grant.sv | 39 +++
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the FSM states, grant encodings and the defaults for timeout behaviour.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 15;

  localparam logic [31:0] TIMEOUT_RDATA = 32'h0000_0000;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational winner select between the fetch and data requesters.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking; otherwise data wins ties.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic i_elig,
  input  logic d_elig,
  input  logic last_grant,
  output logic any_elig,
  output logic winner
);

  assign any_elig = i_elig | d_elig;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    winner = GRANT_D;
    if (i_elig && d_elig) begin
      // On a tie the port that did not win last time goes next
      winner = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (i_elig) begin
      winner = GRANT_I;
    end else begin
      winner = GRANT_D;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    winner = GRANT_D;
    if (i_elig && !d_elig) begin
      winner = GRANT_I;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory between instruction fetch and data ports.
// Tie-break policy: define MEM_ARB_ROUND_ROBIN_EN for round-robin, else data has priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [31:0]       i_rdata,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              mem_valid,
  output logic              mem_instr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              err,
  output logic              busy
);

  // Legal TIMEOUT_CYCLES range is 2..255, so the last count always fits in 8 bits
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t            state_reg, state_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic              last_grant_reg, last_grant_next;
  logic              i_ready_reg, i_ready_next;
  logic [31:0]       i_rdata_reg, i_rdata_next;
  logic              d_ready_reg, d_ready_next;
  logic [31:0]       d_rdata_reg, d_rdata_next;
  logic              mem_valid_reg, mem_valid_next;
  logic              mem_instr_reg, mem_instr_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [31:0]       mem_wdata_reg, mem_wdata_next;
  logic [3:0]        mem_wstrb_reg, mem_wstrb_next;
  logic              err_reg, err_next;

  logic i_elig, d_elig, any_elig, winner;
  logic cur_grant, done_mem, done_timeout;

  // A port whose completion pulse is visible this cycle must not be re-granted
  assign i_elig = i_valid & ~i_ready_reg;
  assign d_elig = d_valid & ~d_ready_reg;

  mem_arb_grant u_grant (
    .i_elig     (i_elig),
    .d_elig     (d_elig),
    .last_grant (last_grant_reg),
    .any_elig   (any_elig),
    .winner     (winner)
  );

  assign cur_grant    = mem_instr_reg ? GRANT_I : GRANT_D;
  assign done_mem     = (state_reg == BUSY) && mem_ready;
  assign done_timeout = (state_reg == BUSY) && !mem_ready && (cnt_reg == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_elig) state_next = BUSY;
      BUSY:    if (done_mem || done_timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_next        = cnt_reg;
    last_grant_next = last_grant_reg;
    i_ready_next    = 1'b0;
    d_ready_next    = 1'b0;
    err_next        = 1'b0;
    i_rdata_next    = i_rdata_reg;
    d_rdata_next    = d_rdata_reg;
    mem_instr_next  = mem_instr_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    mem_wstrb_next  = mem_wstrb_reg;
    mem_valid_next  = (state_next == BUSY);

    if (state_reg == IDLE) begin
      if (any_elig) begin
        cnt_next = '0;
        if (winner == GRANT_I) begin
          mem_instr_next = 1'b1;
          mem_addr_next  = i_addr;
          mem_wdata_next = '0;
          mem_wstrb_next = '0;
        end else begin
          mem_instr_next = 1'b0;
          mem_addr_next  = d_addr;
          mem_wdata_next = d_wdata;
          mem_wstrb_next = d_wstrb;
        end
      end
    end else if (done_mem || done_timeout) begin
      if (cur_grant == GRANT_I) begin
        i_ready_next = 1'b1;
        i_rdata_next = done_mem ? mem_rdata : TIMEOUT_RDATA;
      end else begin
        d_ready_next = 1'b1;
        d_rdata_next = done_mem ? mem_rdata : TIMEOUT_RDATA;
      end
      err_next = done_timeout;
      if (done_mem) last_grant_next = cur_grant;
    end else begin
      cnt_next = cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg        <= '0;
      last_grant_reg <= GRANT_D;
      i_ready_reg    <= 1'b0;
      i_rdata_reg    <= '0;
      d_ready_reg    <= 1'b0;
      d_rdata_reg    <= '0;
      mem_valid_reg  <= 1'b0;
      mem_instr_reg  <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_wstrb_reg  <= '0;
      err_reg        <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      last_grant_reg <= last_grant_next;
      i_ready_reg    <= i_ready_next;
      i_rdata_reg    <= i_rdata_next;
      d_ready_reg    <= d_ready_next;
      d_rdata_reg    <= d_rdata_next;
      mem_valid_reg  <= mem_valid_next;
      mem_instr_reg  <= mem_instr_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      mem_wstrb_reg  <= mem_wstrb_next;
      err_reg        <= err_next;
    end
  end

  assign i_ready   = i_ready_reg;
  assign i_rdata   = i_rdata_reg;
  assign d_ready   = d_ready_reg;
  assign d_rdata   = d_rdata_reg;
  assign mem_valid = mem_valid_reg;
  assign mem_instr = mem_instr_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_wstrb = mem_wstrb_reg;
  assign err       = err_reg;
  assign busy      = mem_valid_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected completions, a monitor checks them.
// Expectations follow MEM_ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_valid = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        err;
  logic        busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit mem_respond = 1'b1;

  typedef struct {
    bit          port;
    logic [31:0] rdata;
    bit          chk_rd;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  mem_arbiter #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: one-cycle registered response, preloaded words for fixed addresses
  logic [31:0] mem_model [0:4095];
  bit          written   [0:4095];

  function automatic logic [31:0] init_word(input logic [11:0] w);
    if (w == 12'h040) return 32'hDEADBEEF;
    if (w >= 12'h400 && w < 12'h410) return 32'h1000_0000 + 32'(w - 12'h400);
    if (w >= 12'h800 && w < 12'h810) return 32'h2000_0000 + 32'(w - 12'h800);
    return 32'h0;
  endfunction

  function automatic logic [31:0] rd_word(input logic [11:0] w);
    return written[w] ? mem_model[w] : init_word(w);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_valid && !mem_ready && mem_respond) begin
      mem_ready <= 1'b1;
      mem_rdata <= rd_word(mem_addr[13:2]);
      if (mem_wstrb != 4'h0) begin
        mem_model[mem_addr[13:2]] <= merge(rd_word(mem_addr[13:2]), mem_wdata, mem_wstrb);
        written[mem_addr[13:2]]   <= 1'b1;
      end
    end else begin
      mem_ready <= 1'b0;
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pops one expected completion per ready pulse
  always @(negedge clk) begin : monitor
    exp_t e;
    if (i_ready || d_ready) begin
      if (i_ready && d_ready) begin
        total++; bad++;
        $display("FAIL both_ready: got i_ready=1 d_ready=1 expected one port (cyc %0d)", cyc);
      end else if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_ready: got ready on port %0d expected none (cyc %0d)",
                 d_ready, cyc);
      end else begin
        e = sb.pop_front();
        $display("txn cyc=%0d port=%s rdata=%08h err=%0b", cyc, d_ready ? "D" : "I",
                 d_ready ? d_rdata : i_rdata, err);
        chk("done_port", 32'(d_ready), 32'(e.port));
        chk("done_cycle", cyc, e.cyc);
        chk("done_err", 32'(err), 32'(e.err));
        if (e.chk_rd) chk("done_rdata", d_ready ? d_rdata : i_rdata, e.rdata);
      end
    end else if (err) begin
      total++; bad++;
      $display("FAIL err_without_ready: got err=1 expected 0 (cyc %0d)", cyc);
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_i_ready"}, 32'(i_ready), 0);
    chk({tag, "_d_ready"}, 32'(d_ready), 0);
    chk({tag, "_mem_valid"}, 32'(mem_valid), 0);
    chk({tag, "_mem_instr"}, 32'(mem_instr), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_i_rdata"}, i_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 0);
  endtask

  task automatic req(input bit port, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input logic [31:0] exp_rdata,
                     input bit chk_rd, input bit exp_err);
    exp_t e;
    int   c;
    bit   seen;
    @(posedge clk); #1;
    c = cyc;
    if (port == GRANT_I) begin
      i_valid = 1'b1; i_addr = addr;
    end else begin
      d_valid = 1'b1; d_addr = addr; d_wdata = wdata; d_wstrb = wstrb;
    end
    e.port = port; e.rdata = exp_rdata; e.chk_rd = chk_rd; e.err = exp_err;
    e.cyc = c + (exp_err ? TO + 1 : 3);
    sb.push_back(e);
    @(negedge clk);
    @(negedge clk);
    chk("grant_mem_valid", 32'(mem_valid), 1);
    chk("grant_mem_instr", 32'(mem_instr), 32'(port == GRANT_I));
    chk("grant_mem_addr", mem_addr, addr);
    chk("grant_mem_wstrb", 32'(mem_wstrb), (port == GRANT_D) ? 32'(wstrb) : 0);
    chk("grant_mem_wdata", mem_wdata, (port == GRANT_D) ? wdata : 0);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if ((port == GRANT_I) ? i_ready : d_ready) seen = 1'b1;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL req_wait: got no ready expected ready within 40 cycles (cyc %0d)", cyc);
    end
    if (port == GRANT_I) i_valid = 1'b0; else d_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  function automatic bit first_tie_port();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    return GRANT_I;
`else
    return GRANT_D;
`endif
  endfunction

  task automatic tie();
    exp_t e;
    int   c;
    bit   idone, ddone;
    bit   first;
    first = first_tie_port();
    @(posedge clk); #1;
    c = cyc;
    i_valid = 1'b1; i_addr = 32'h100;
    d_valid = 1'b1; d_addr = 32'h200; d_wdata = '0; d_wstrb = 4'h0;
    for (int k = 0; k < 2; k++) begin
      e.port   = (k == 0) ? first : ~first;
      e.rdata  = (e.port == GRANT_I) ? 32'hDEADBEEF : 32'h00003344;
      e.chk_rd = 1'b1; e.err = 1'b0; e.cyc = c + 3 * (k + 1);
      sb.push_back(e);
    end
    @(negedge clk);
    @(negedge clk);
    chk("tie_first_instr", 32'(mem_instr), 32'(first == GRANT_I));
    idone = 1'b0; ddone = 1'b0;
    for (int k = 0; k < 20 && !(idone && ddone); k++) begin
      @(negedge clk);
      if (i_ready) begin idone = 1'b1; i_valid = 1'b0; end
      if (d_ready) begin ddone = 1'b1; d_valid = 1'b0; end
    end
    if (!(idone && ddone)) begin
      total++; bad++;
      $display("FAIL tie_wait: got i=%0b d=%0b expected both done", idone, ddone);
    end
    i_valid = 1'b0; d_valid = 1'b0;
  endtask

  task automatic burst();
    exp_t e;
    int   c, ik, dk;
    bit   first;
    first = first_tie_port();
    @(posedge clk); #1;
    c = cyc;
    i_valid = 1'b1; i_addr = 32'h1000;
    d_valid = 1'b1; d_addr = 32'h2000; d_wdata = '0; d_wstrb = 4'h0;
    ik = 0; dk = 0;
    for (int k = 1; k <= 10; k++) begin
      e.port = (k % 2 == 1) ? first : ~first;
      if (e.port == GRANT_I) begin e.rdata = 32'h1000_0000 + 32'(ik); ik++; end
      else begin e.rdata = 32'h2000_0000 + 32'(dk); dk++; end
      e.chk_rd = 1'b1; e.err = 1'b0; e.cyc = c + 3 * k;
      sb.push_back(e);
    end
    ik = 0; dk = 0;
    for (int n = 0; n <= 30; n++) begin
      @(negedge clk);
      if (i_ready) begin ik++; i_addr = 32'h1000 + 32'(4 * ik); end
      if (d_ready) begin dk++; d_addr = 32'h2000 + 32'(4 * dk); end
    end
    i_valid = 1'b0; d_valid = 1'b0;
    chk("burst_i_count", ik, 5);
    chk("burst_d_count", dk, 5);
  endtask

  initial begin : main
    repeat (3) @(negedge clk);
    check_zero("reset");
    resetn = 1'b1;

    req(GRANT_I, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1, 1'b0);
    req(GRANT_D, 32'h200, 32'h11223344, 4'b0011, 32'h0, 1'b0, 1'b0);
    req(GRANT_D, 32'h200, 32'h0, 4'h0, 32'h00003344, 1'b1, 1'b0);

    pulse_reset();
    tie();
    burst();

    mem_respond = 1'b0;
    req(GRANT_D, 32'h300, 32'h0, 4'h0, TIMEOUT_RDATA, 1'b1, 1'b1);
    @(negedge clk);
    chk("timeout_busy_after", 32'(busy), 0);
    chk("timeout_mem_valid_after", 32'(mem_valid), 0);

    // Abandon an in-flight data access with reset
    @(posedge clk); #1;
    d_valid = 1'b1; d_addr = 32'h400; d_wdata = '0; d_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 1);
    resetn = 1'b0;
    #1;
    check_zero("abort");
    repeat (3) @(negedge clk);
    d_valid = 1'b0;
    resetn = 1'b1;
    mem_respond = 1'b1;
    req(GRANT_I, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000 time units");
    $fatal(1, "bench timed out");
  end

endmodule
